tap_controller: RTL and testbench

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_controller_if.sv | 33 +++
 rtl/tap_controller.sv | 218 +++++++++++++++++++++
 tb/tb_tap_controller.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_controller_if.sv
// Signal bundle between an IEEE 1149.1 TAP controller and its test host / scan chain.
// TMS/TDI are sampled on rising TCK; TDO, Enable and the Update strobes change on falling TCK.
interface tap_controller_if;
    logic       TMS;
    logic       TDI;
    logic       TDO_BR;
    logic       TDO_BSR;
    logic       TDO;
    logic       Enable;
    logic       CaptureDR;
    logic       ShiftDR;
    logic       UpdateDR;
    logic       ClockDR;
    logic       ShiftIR;
    logic       UpdateIR;
    logic       Mode;
    logic       SelBR;
    logic       SelBSR;
    logic       TLReset_n;
    logic [3:0] State;

    modport master (
        output TMS, TDI, TDO_BR, TDO_BSR,
        input  TDO, Enable, CaptureDR, ShiftDR, UpdateDR, ClockDR,
        input  ShiftIR, UpdateIR, Mode, SelBR, SelBSR, TLReset_n, State
    );

    modport slave (
        input  TMS, TDI, TDO_BR, TDO_BSR,
        output TDO, Enable, CaptureDR, ShiftDR, UpdateDR, ClockDR,
        output ShiftIR, UpdateIR, Mode, SelBR, SelBSR, TLReset_n, State
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with 2-bit IR (EXTEST/SAMPLE/IDCODE/BYPASS).
// Optional 32-bit IDCODE register enabled by defining TAP_IDCODE_EN; otherwise IR 10 acts as BYPASS.
module tap_controller #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic           TCK,
    input  logic           TRST,
    tap_controller_if.slave jtag
);

    typedef enum logic [3:0] {
        S_EX2DR = 4'h0,
        S_EX1DR = 4'h1,
        S_SHDR  = 4'h2,
        S_PAUDR = 4'h3,
        S_SELIR = 4'h4,
        S_UPDDR = 4'h5,
        S_CAPDR = 4'h6,
        S_SELDR = 4'h7,
        S_EX2IR = 4'h8,
        S_EX1IR = 4'h9,
        S_SHIR  = 4'hA,
        S_PAUIR = 4'hB,
        S_RTI   = 4'hC,
        S_UPDIR = 4'hD,
        S_CAPIR = 4'hE,
        S_TLR   = 4'hF
    } tap_state_t;

    localparam logic [1:0] IR_EXTEST = 2'b00;
    localparam logic [1:0] IR_SAMPLE = 2'b01;
    localparam logic [1:0] IR_IDCODE = 2'b10;
`ifdef TAP_IDCODE_EN
    localparam logic [1:0] IR_RESET  = IR_IDCODE;
`else
    localparam logic [1:0] IR_RESET  = 2'b11;
`endif

    tap_state_t r_state;
    tap_state_t w_next;

    logic       w_tlr;
    logic       w_cap_dr;
    logic       w_sh_dr;
    logic       w_upd_dr_st;
    logic       w_sh_ir;
    logic       w_upd_ir_st;

    logic [1:0] r_ir_sh;
    logic [1:0] r_ir;
    logic [1:0] w_ir;

    logic       w_sel_br;
    logic       w_sel_bsr;
    logic       w_sel_id;
    logic       w_mode;
    logic       w_id_tdo;
    logic       w_tdo_d;

    logic       r_upd_dr;
    logic       r_upd_ir;
    logic       r_clk_en;
    logic       r_en;
    logic       r_tdo;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_TLR;
        case (r_state)
            S_TLR:   w_next = jtag.TMS ? S_TLR   : S_RTI;
            S_RTI:   w_next = jtag.TMS ? S_SELDR : S_RTI;
            S_SELDR: w_next = jtag.TMS ? S_SELIR : S_CAPDR;
            S_CAPDR: w_next = jtag.TMS ? S_EX1DR : S_SHDR;
            S_SHDR:  w_next = jtag.TMS ? S_EX1DR : S_SHDR;
            S_EX1DR: w_next = jtag.TMS ? S_UPDDR : S_PAUDR;
            S_PAUDR: w_next = jtag.TMS ? S_EX2DR : S_PAUDR;
            S_EX2DR: w_next = jtag.TMS ? S_UPDDR : S_SHDR;
            S_UPDDR: w_next = jtag.TMS ? S_SELDR : S_RTI;
            S_SELIR: w_next = jtag.TMS ? S_TLR   : S_CAPIR;
            S_CAPIR: w_next = jtag.TMS ? S_EX1IR : S_SHIR;
            S_SHIR:  w_next = jtag.TMS ? S_EX1IR : S_SHIR;
            S_EX1IR: w_next = jtag.TMS ? S_UPDIR : S_PAUIR;
            S_PAUIR: w_next = jtag.TMS ? S_EX2IR : S_PAUIR;
            S_EX2IR: w_next = jtag.TMS ? S_UPDIR : S_SHIR;
            S_UPDIR: w_next = jtag.TMS ? S_SELDR : S_RTI;
            default: w_next = S_TLR;
        endcase
    end

    always_comb begin
        w_tlr       = (r_state == S_TLR);
        w_cap_dr    = (r_state == S_CAPDR);
        w_sh_dr     = (r_state == S_SHDR);
        w_upd_dr_st = (r_state == S_UPDDR);
        w_sh_ir     = (r_state == S_SHIR);
        w_upd_ir_st = (r_state == S_UPDIR);
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_ir_sh <= 2'b01;
        end else if (r_state == S_CAPIR) begin
            r_ir_sh <= 2'b01;
        end else if (w_sh_ir) begin
            r_ir_sh <= {jtag.TDI, r_ir_sh[1]};
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_ir <= IR_RESET;
        end else if (w_tlr) begin
            r_ir <= IR_RESET;
        end else if (w_upd_ir_st) begin
            r_ir <= r_ir_sh;
        end
    end

    // The latch itself updates on falling TCK; the override makes the reset
    // instruction effective on the very rising edge that enters Test-Logic-Reset.
    assign w_ir = w_tlr ? IR_RESET : r_ir;

    always_comb begin
        w_sel_br  = 1'b0;
        w_sel_bsr = 1'b0;
        w_sel_id  = 1'b0;
        w_mode    = 1'b0;
        case (w_ir)
            IR_EXTEST: begin
                w_sel_bsr = 1'b1;
                w_mode    = 1'b1;
            end
            IR_SAMPLE: w_sel_bsr = 1'b1;
`ifdef TAP_IDCODE_EN
            IR_IDCODE: w_sel_id  = 1'b1;
`else
            IR_IDCODE: w_sel_br  = 1'b1;
`endif
            default:   w_sel_br  = 1'b1;
        endcase
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] r_idcode;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_idcode <= IDCODE_VALUE;
        end else if (w_sel_id && w_cap_dr) begin
            r_idcode <= IDCODE_VALUE;
        end else if (w_sel_id && w_sh_dr) begin
            r_idcode <= {jtag.TDI, r_idcode[31:1]};
        end
    end

    assign w_id_tdo = r_idcode[0];
`else
    logic w_unused_idcode;

    assign w_unused_idcode = ^IDCODE_VALUE;
    assign w_id_tdo        = 1'b0;
`endif

    always_comb begin
        w_tdo_d = 1'b0;
        if (w_sh_ir) begin
            w_tdo_d = r_ir_sh[0];
        end else if (w_sh_dr) begin
            if (w_sel_id) begin
                w_tdo_d = w_id_tdo;
            end else if (w_sel_bsr) begin
                w_tdo_d = jtag.TDO_BSR;
            end else begin
                w_tdo_d = jtag.TDO_BR;
            end
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_upd_dr <= 1'b0;
            r_upd_ir <= 1'b0;
            r_clk_en <= 1'b0;
            r_en     <= 1'b0;
            r_tdo    <= 1'b0;
        end else begin
            r_upd_dr <= w_upd_dr_st;
            r_upd_ir <= w_upd_ir_st;
            r_clk_en <= w_cap_dr | w_sh_dr;
            r_en     <= w_sh_dr | w_sh_ir;
            r_tdo    <= w_tdo_d;
        end
    end

    // Enable changes only while TCK is low, so the AND cannot glitch.
    assign jtag.ClockDR   = TCK & r_clk_en;
    // Qualified by the state so the strobe drops on the rising edge leaving Update.
    assign jtag.UpdateDR  = r_upd_dr & w_upd_dr_st;
    assign jtag.UpdateIR  = r_upd_ir & w_upd_ir_st;
    assign jtag.CaptureDR = w_cap_dr;
    assign jtag.ShiftDR   = w_sh_dr;
    assign jtag.ShiftIR   = w_sh_ir;
    assign jtag.Enable    = r_en;
    assign jtag.TDO       = r_tdo;
    assign jtag.Mode      = w_mode;
    assign jtag.SelBR     = w_sel_br;
    assign jtag.SelBSR    = w_sel_bsr;
    assign jtag.TLReset_n = ~w_tlr;
    assign jtag.State     = r_state;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed scans plus random TMS walks
// compared against a table-driven TAP model (TAP_IDCODE_EN selects the IDCODE variant).
module tb_tap_controller;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [1:0] IR_RST = ID_EN ? 2'b10 : 2'b11;
  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, CAPDR = 4'h6, SHDR = 4'h2;
  localparam logic [3:0] UPDDR = 4'h5, CAPIR = 4'hE, SHIR = 4'hA, UPDIR = 4'hD;

  // next-state tables indexed by state code: [code] -> successor for TMS=0 / TMS=1
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  logic TCK;
  logic TRST;
  tap_controller_if jtag();

  tap_controller #(.IDCODE_VALUE(IDV)) u_dut (
    .TCK  (TCK),
    .TRST (TRST),
    .jtag (jtag)
  );

  // clock/reset block
  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int clk_cnt = 0;
  int upd_dr_cnt = 0;
  int upd_ir_cnt = 0;
  int exp_pulses = 0;

  always @(posedge jtag.ClockDR) clk_cnt++;
  always @(posedge jtag.UpdateDR) upd_dr_cnt++;
  always @(posedge jtag.UpdateIR) upd_ir_cnt++;

  // reference model
  logic [3:0]  m_state;
  logic [1:0]  m_ir;
  logic [1:0]  m_sh;
  logic [31:0] m_id;
  logic        m_br;
  logic        m_bsr;
  logic [0:0]  exp_q[$];

  function automatic logic [2:0] dec(input logic [1:0] ir);
    case (ir)
      2'b00:   return 3'b011;
      2'b01:   return 3'b010;
      2'b10:   return ID_EN ? 3'b000 : 3'b100;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic m_tdo();
    if (m_state == SHIR) return m_sh[0];
    if (m_state != SHDR) return 1'b0;
    case (m_ir)
      2'b00, 2'b01: return m_bsr;
      2'b10:        return ID_EN ? m_id[0] : m_br;
      default:      return m_br;
    endcase
  endfunction

  task automatic model_reset();
    m_state = TLR;
    m_ir    = IR_RST;
    m_sh    = 2'b01;
    m_id    = IDV;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one TCK cycle, checks after the rising and after the falling edge
  task automatic step(input logic tms, input logic tdi);
    logic [3:0] s;
    s = m_state;
    jtag.TMS = tms;
    jtag.TDI = tdi;
    jtag.TDO_BSR = 1'($urandom_range(0, 1));
    m_bsr = jtag.TDO_BSR;
    @(posedge TCK);
    #1;
    if (s == CAPIR) m_sh = 2'b01;
    else if (s == SHIR) m_sh = {tdi, m_sh[1]};
    if (ID_EN && m_ir == 2'b10) begin
      if (s == CAPDR) m_id = IDV;
      else if (s == SHDR) m_id = {tdi, m_id[31:1]};
    end
    if (s == CAPDR) m_br = 1'b0;
    else if (s == SHDR) m_br = tdi;
    if (s == CAPDR || s == SHDR) exp_pulses++;
    m_state = tms ? nxt1[s] : nxt0[s];
    if (m_state == TLR) m_ir = IR_RST;
    jtag.TDO_BR = m_br;
    chk("post_edge", 32'({jtag.State, jtag.TLReset_n, jtag.CaptureDR, jtag.ShiftDR, jtag.ShiftIR,
                          jtag.UpdateDR, jtag.UpdateIR, jtag.SelBR, jtag.SelBSR, jtag.Mode}),
        32'({m_state, m_state != TLR, m_state == CAPDR, m_state == SHDR, m_state == SHIR,
             2'b00, dec(m_ir)}));
    @(negedge TCK);
    #1;
    if (m_state == UPDIR) m_ir = m_sh;
    chk("neg_edge", 32'({jtag.Enable, jtag.TDO, jtag.UpdateDR, jtag.UpdateIR,
                         jtag.SelBR, jtag.SelBSR, jtag.Mode}),
        32'({m_state == SHDR || m_state == SHIR, m_tdo(), m_state == UPDDR, m_state == UPDIR,
             dec(m_ir)}));
  endtask

  // asynchronous reset pulse placed inside the low phase of TCK
  task automatic trst_pulse(input string tag);
    #2 TRST = 1'b0;
    #1;
    model_reset();
    chk(tag, 32'({jtag.State, jtag.TLReset_n, jtag.Enable, jtag.TDO, jtag.UpdateDR, jtag.UpdateIR,
                  jtag.CaptureDR, jtag.ShiftDR, jtag.ShiftIR, jtag.SelBR, jtag.SelBSR, jtag.Mode}),
        32'({TLR, 8'h00, dec(IR_RST)}));
    TRST = 1'b1;
  endtask

  // from RTI: load v into IR, return the two bits seen on TDO while shifting
  task automatic load_ir(input logic [1:0] v, output logic [1:0] seen);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    seen[0] = jtag.TDO;
    step(1'b0, v[0]);
    seen[1] = jtag.TDO;
    step(1'b1, v[1]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0]  seen;
    logic [31:0] got;
    int          p0;
    int          u0;
    int          n;
    bit          tdi_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    TRST = 1'b1;
    jtag.TMS = 1'b1;
    jtag.TDI = 1'b0;
    jtag.TDO_BR = 1'b0;
    jtag.TDO_BSR = 1'b0;
    m_br = 1'b0;
    m_bsr = 1'b0;
    trst_pulse("reset_state");

    // five TMS=1 edges from RTI reach TLR and stay there
    step(1'b0, 1'b0);
    chk("rti", 32'(jtag.State), 32'(RTI));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tlr_after5", 32'(jtag.State), 32'(TLR));
    step(1'b1, 1'b0);
    chk("tlr_hold", 32'(jtag.State), 32'(TLR));
    step(1'b0, 1'b0);

    load_ir(2'b11, seen);
    chk("ir_capture_01", 32'(seen), 32'(2'b01));
    chk("bypass_selbr", 32'({jtag.SelBR, jtag.SelBSR, jtag.Mode}), 32'(3'b100));

    // bypass DR scan: one-bit delay through the external bypass flop
    p0 = clk_cnt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bypass_tdo", 32'(jtag.TDO), 32'(exp_q.pop_front()));
      exp_q.push_back(tdi_seq[i]);
      step(i == 3, tdi_seq[i]);
    end
    exp_q.delete();
    chk("bypass_clockdr", 32'(clk_cnt - p0), 32'd5);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

`ifdef TAP_IDCODE_EN
    trst_pulse("reset_idcode");
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    got = '0;
    for (int i = 0; i < 32; i++) begin
      got[i] = jtag.TDO;
      step(i == 31, 1'($urandom_range(0, 1)));
    end
    chk("idcode_value", got, IDV);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
`else
    load_ir(2'b10, seen);
    chk("ir10_is_bypass", 32'({jtag.SelBR, jtag.SelBSR, jtag.Mode}), 32'(3'b100));
`endif

    // EXTEST: boundary register path, single UpdateDR pulse
    load_ir(2'b00, seen);
    chk("extest_decode", 32'({jtag.Mode, jtag.SelBSR, jtag.SelBR}), 32'(3'b110));
    u0 = upd_dr_cnt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      chk("extest_tdo", 32'(jtag.TDO), 32'(m_bsr));
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("upd_dr_high", 32'(jtag.UpdateDR), 32'd1);
    step(1'b0, 1'b0);
    chk("upd_dr_low", 32'(jtag.UpdateDR), 32'd0);
    chk("upd_dr_count", 32'(upd_dr_cnt - u0), 32'd1);

    // TRST aborts a DR shift and an IR shift with no update strobes
    u0 = upd_dr_cnt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    trst_pulse("trst_mid_shdr");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("no_upd_dr", 32'(upd_dr_cnt - u0), 32'd0);
    u0 = upd_ir_cnt;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    trst_pulse("trst_mid_shir");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("no_upd_ir", 32'(upd_ir_cnt - u0), 32'd0);

    // random TMS walks, each closed by five TMS=1 edges
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(3, 30);
      for (int k = 0; k < n; k++) begin
        step($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 39) == 0) trst_pulse("trst_rand");
      end
      for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom_range(0, 1)));
      chk("rand_tlr5", 32'(jtag.State), 32'(TLR));
    end

    chk("clockdr_total", 32'(clk_cnt), 32'(exp_pulses));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
